// File: rtl/uart_pkg.sv
// Shared state encoding and frame-bit constants for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter draining a first-word-fall-through fifo.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, pops a byte as soon as the fifo is non-empty
// START  | start bit on the line
// DATA   | data bits, LSB first
// PARITY | even parity over the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit; returns to IDLE for one cycle before the next pop
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       empty,
  output logic       pop,
  output logic       tx,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic       tx_q, tx_nxt;
  logic       baud_clear, baud_tick;
`ifdef UART_TX_PARITY_EN
  logic       parity_q;
`endif

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // tx_nxt is the line level for the state being entered, so tx stays aligned with state.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    bit_nxt    = bit_cnt;
    tx_nxt     = tx_q;
    pop        = 1'b0;
    baud_clear = 1'b0;
    case (state)
      IDLE: begin
        baud_clear = 1'b1;
        bit_nxt    = 3'd0;
        tx_nxt     = STOP_BIT;
        if (!empty && !rst) begin
          pop       = 1'b1;
          shift_nxt = data_in;
          state_nxt = START;
          tx_nxt    = START_BIT;
        end
      end
      START: begin
        if (baud_tick) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
          tx_nxt    = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = parity_q;
`else
            state_nxt = STOP;
            tx_nxt    = STOP_BIT;
`endif
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            shift_nxt = shift_reg >> 1;
            tx_nxt    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_nxt = STOP;
          tx_nxt    = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_nxt = IDLE;
          tx_nxt    = STOP_BIT;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx_q      <= STOP_BIT;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_nxt;
      tx_q      <= tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= ^data_in;
    end
  end
`endif

  assign tx   = tx_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus directed scenarios.
module tb_uart_tx;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       pop, tx, busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  uart_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .empty   (empty),
    .pop     (pop),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position within the current frame and the frame's bit sequence.
  int   m_pos = -1;
  logic m_fb[NB];

  always @(posedge clk) begin
    if (rst) begin
      m_pos <= -1;
    end else if (m_pos < 0) begin
      if (!empty) begin
        m_pos    <= 0;
        m_fb[0]  <= 1'b0;
        for (int i = 0; i < 8; i++) m_fb[i+1] <= data_in[i];
`ifdef UART_TX_PARITY_EN
        m_fb[9]  <= ^data_in;
`endif
        m_fb[NB-1] <= 1'b1;
      end
    end else if (m_pos == FL - 1) begin
      m_pos <= -1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_pop", 32'(pop), 32'(!rst && m_pos < 0 && !empty));
        chk("cyc_tx", 32'(tx), (m_pos < 0) ? 32'd1 : 32'(m_fb[m_pos / CLK_DIV]));
        chk("cyc_busy", 32'(busy), 32'(m_pos >= 0));
      end
    end
  end

  // Line decoder recovering bytes (and parity) from tx by mid-bit sampling.
  int         rx_cnt = -1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par = 1'b0;
  logic [7:0] rx_q[$];
  logic       rx_par_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) rx_cnt = -1;
      else if (rx_cnt < 0) begin
        if (tx === 1'b0) rx_cnt = 0;
      end else rx_cnt++;
      if (rx_cnt >= 0 && rx_cnt % CLK_DIV == CLK_DIV / 2) begin
        automatic int k = rx_cnt / CLK_DIV;
        if (k >= 1 && k <= 8) rx_byte[k-1] = tx;
        else if (k == NB - 1) begin
          rx_q.push_back(rx_byte);
          rx_par_q.push_back(rx_par);
          rx_cnt = -1;
        end else if (k == 9) rx_par = tx;
      end
    end
  end

  logic [7:0] fq[$];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Serves fq as a FWFT fifo for a fixed number of cycles.
  task automatic run_fifo(input int cycles, output int npop, output int gap_bad, output int nbusy);
    int last;
    bit p;
    last = -1; npop = 0; gap_bad = 0; nbusy = 0;
    empty = (fq.size() == 0);
    data_in = (fq.size() != 0) ? fq[0] : 8'h00;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      p = pop;
      if (busy) nbusy++;
      if (p) begin
        npop++;
        if (last >= 0 && c - last != FL + 1) gap_bad++;
        last = c;
      end
      next_cycle();
      if (p) void'(fq.pop_front());
      empty = (fq.size() == 0);
      data_in = (fq.size() != 0) ? fq[0] : 8'h00;
    end
  endtask

  initial begin
    int busy_cnt, np, gb, nb, ntxlow;
`ifdef UART_TX_PARITY_EN
    int pat55[NB] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
    int pat55[NB] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

    rst = 1'b1; empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);

    // fifo non-empty while held in reset: no pop until rst drops
    next_cycle();
    empty = 1'b0; data_in = 8'h55;
    @(negedge clk);
    chk("rst_pop_hold", 32'(pop), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("first_pop", 32'(pop), 32'd1);
    next_cycle();
    empty = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < FL + 10; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i < FL && i % CLK_DIV == CLK_DIV / 2)
        chk($sformatf("b55_bit%0d", i / CLK_DIV), 32'(tx), 32'(pat55[i / CLK_DIV]));
    end
    chk("b55_busy_len", 32'(busy_cnt), 32'(FL));
    chk("b55_tx_after", 32'(tx), 32'd1);

    // quiet line after reset
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    np = 0; ntxlow = 0; nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pop) np++;
      if (tx !== 1'b1) ntxlow++;
      if (busy) nb++;
    end
    chk("idle_pops", 32'(np), 32'd0);
    chk("idle_txlow", 32'(ntxlow), 32'd0);
    chk("idle_busy", 32'(nb), 32'd0);

    // back-to-back frames
    next_cycle();
    rx_q.delete(); rx_par_q.delete();
    fq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_fifo(4 * (FL + 1) + 10, np, gb, nb);
    chk("b2b_pops", 32'(np), 32'd4);
    chk("b2b_gap", 32'(gb), 32'd0);
    chk("b2b_busy", 32'(nb), 32'(4 * FL));
    chk("b2b_rxn", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (rx_q.size() > i) chk($sformatf("b2b_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));

    // reset in the middle of a frame
    rx_q.delete();
    empty = 1'b0; data_in = 8'hA5;
    @(negedge clk);
    chk("mid_pop", 32'(pop), 32'd1);
    next_cycle();
    empty = 1'b1; data_in = 8'h3C;
    repeat (12) next_cycle();
    rst = 1'b1; empty = 1'b0;
    @(negedge clk);
    chk("mid_rst_pop", 32'(pop), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_tx", 32'(tx), 32'd1);
    chk("mid_after_busy", 32'(busy), 32'd0);
    chk("mid_after_pop", 32'(pop), 32'd1);
    next_cycle();
    empty = 1'b1;
    repeat (FL + 5) next_cycle();
    chk("mid_rxn", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("mid_byte", 32'(rx_q[0]), 32'h3C);

    // inputs churn during the frame
    rx_q.delete();
    np = 0;
    empty = 1'b0; data_in = 8'hC3;
    @(negedge clk);
    if (pop) np++;
    next_cycle();
    for (int c = 1; c <= FL - 3; c++) begin
      empty = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      @(negedge clk);
      if (pop) np++;
      next_cycle();
    end
    empty = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pop) np++;
      next_cycle();
    end
    chk("churn_pops", 32'(np), 32'd1);
    chk("churn_rxn", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("churn_byte", 32'(rx_q[0]), 32'hC3);

`ifdef UART_TX_PARITY_EN
    rx_q.delete(); rx_par_q.delete();
    fq = '{8'h07, 8'h03};
    run_fifo(2 * (FL + 1) + 10, np, gb, nb);
    chk("par_pops", 32'(np), 32'd2);
    chk("par_busy", 32'(nb), 32'd88);
    chk("par_rxn", 32'(rx_par_q.size()), 32'd2);
    if (rx_par_q.size() > 1) begin
      chk("par_bit_07", 32'(rx_par_q[0]), 32'd1);
      chk("par_bit_03", 32'(rx_par_q[1]), 32'd0);
      chk("par_byte_07", 32'(rx_q[0]), 32'h07);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
